countdown15: RTL and testbench
==============================

# countdown15

Loadable modulo-15 down counter, the count-down counterpart of the `count15` up counter. It takes the same `init`/`set` load interface and counts from the loaded value toward 0. It then either stops (one-shot) or wraps to 14 (continuous). It provides timeout and interval timing for blocks that already drive `count15`, and its 4-bit `out` is directly comparable with `count15.out`.

## Interface
Parameters:
- `MOD` — default 15 — counter modulus; count range is `MOD-1` down to 0; legal range 2..16.
- `WIDTH` — default 4 — width of `init` and `out`; must satisfy `2**WIDTH >= MOD`.

Ports:
- `clk` — input, 1 — single clock; all state updates on the rising edge.
- `reset` — input, 1 — asynchronous, active-high reset.
- `init` — input, WIDTH — load value, sampled when `set`=1.
- `set` — input, 1 — synchronous load strobe.
- `en` — input, 1 — count enable; one decrement per enabled cycle in RUN.
- `mode` — input, 1 — 0 = one-shot, 1 = continuous; sampled with `set` and held internally.
- `out` — output, WIDTH — current count (registered).
- `tc` — output, 1 — terminal-count pulse (registered).
- `busy` — output, 1 — high in RUN.
- `done` — output, 1 — high in DONE (one-shot finished).
- `wraps` — output, 4 — wrap counter; present only with `COUNTDOWN15_WRAPCNT_EN`.

## Operation
- **States and reset:** IDLE, RUN, DONE.
  - Reset enters IDLE with `out`=0, `tc`=0, `busy`=0, `done`=0, `wraps`=0, and stored mode = 0.
- **Load:** `set`=1 in any state loads `out` ← `init`, saturated to `MOD-1` when `init >= MOD`.
  - The load also captures `mode`, clears `done` and `wraps`, and enters RUN.
  - `set` has priority over `en`.
- **IDLE:** `out` holds. `en` is ignored.
- **RUN, `en`=1, `out`>0:** `out` ← `out`-1.
  - When the result is 0, `tc`=1 for exactly the cycle `out` first shows 0.
  - One-shot mode: the same edge moves the block to DONE.
- **RUN, `en`=1, `out`=0 (continuous mode):** `out` ← `MOD-1`, `wraps` increments (saturating at 15), no `tc`.
- **RUN, `en`=0:** `out` holds and `tc` is 0.
- **DONE:** `out` holds 0, `done`=1, `en` is ignored; only `set` or `reset` leaves.
- **Load of 0:**
  - Enters RUN with `out`=0 and no `tc`, because `tc` marks only a decrement to 0.
  - One-shot: stays in RUN at 0 until the next `en`, then moves to DONE with no `tc`.
  - Continuous: the next `en` wraps to `MOD-1`.
- **Arithmetic:** all arithmetic is unsigned modulo `MOD`; `out` never exceeds `MOD-1`.

## Timing
- **Load latency:** 1 cycle; `set` at edge N gives `out`=sat(`init`) and `busy`=1 after edge N.
- **Decrement latency:** 1 cycle per enabled edge.
  - `tc` and `done` become valid after the same edge that produces `out`=0.
- **`tc` width:** never longer than one cycle, including when `en` stays high.
- **Full one-shot run:** a load of value V with continuous `en` reaches `out`=0 after V enabled edges.
- **Full continuous period:** `MOD` enabled edges.
- **Simultaneous `set` and `en`:** the load wins and no decrement happens that cycle.
- **Load while `out`=1:** pending `tc` is suppressed.
- **Reset mid-count:** `reset` asserted at any time forces all outputs to their reset values immediately, without waiting for a clock edge.
  - After release, the block stays in IDLE until the next `set`.
- **Mode change:** `mode` changes outside a `set` cycle have no effect.

## Configuration
- `COUNTDOWN15_WRAPCNT_EN` defined:
  - The `wraps` port and its 4-bit saturating register exist.
  - `wraps` increments on each continuous-mode wrap (0 → `MOD-1`) and is cleared by `reset` and `set`.
- Undefined:
  - The `wraps` port and register are absent.
  - All other behaviour is identical, cycle for cycle.

## Test plan
- **Reset:** assert `reset` mid-count at `out`=7 → `out`=0, `busy`=0, `done`=0 immediately; no activity until `set`.
- **One-shot run:** `set` with `init`=5, `mode`=0, then `en` held high → `out` goes 5,4,3,2,1,0; `tc`=1 only in the cycle `out`=0; `done`=1 and `busy`=0 from then on; further `en` leaves `out`=0.
- **Continuous run:** `set` with `init`=2, `mode`=1, `en` high → `out` goes 2,1,0,14,13; `tc` pulses once; `wraps`=1 with the macro defined.
- **Saturation and load of 0:**
  - `init`=15 → `out`=14 after load.
  - `init`=0, `mode`=1 → no `tc`; next `en` gives `out`=14.
- **Simultaneous events:**
  - At `out`=1, assert `set` (`init`=9) together with `en` → `out`=9, no `tc`, `wraps` cleared.
  - `en` low for 3 cycles → `out` holds.
- **Wrap saturation (macro defined):** 20 continuous wraps with `MOD`=15 → `wraps` saturates at 15.

Source files
------------

// File: rtl/countdown15.sv
// countdown15: loadable modulo-MOD down counter with one-shot/continuous modes.
// Optional wrap counter port enabled by defining COUNTDOWN15_WRAPCNT_EN.
module countdown15 #(
  parameter int MOD   = 15,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] init,
  input  logic             set,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
`ifdef COUNTDOWN15_WRAPCNT_EN
  output logic             done,
  output logic [3:0]       wraps
`else
  output logic             done
`endif
);

  localparam logic [1:0]       S_IDLE = 2'd0;
  localparam logic [1:0]       S_RUN  = 2'd1;
  localparam logic [1:0]       S_DONE = 2'd2;
  localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH:0]   MODW   = (WIDTH + 1)'(MOD);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             r_mode;
  logic [WIDTH-1:0] w_load_val;
`ifdef COUNTDOWN15_WRAPCNT_EN
  logic [3:0]       r_wraps;
`endif

  // Out-of-range loads clamp to the top of the count range.
  assign w_load_val = ({1'b0, init} >= MODW) ? MAXV : init;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_tc    <= 1'b0;
      r_mode  <= 1'b0;
`ifdef COUNTDOWN15_WRAPCNT_EN
      r_wraps <= '0;
`endif
    end else if (set) begin
      r_state <= S_RUN;
      r_out   <= w_load_val;
      r_tc    <= 1'b0;
      r_mode  <= mode;
`ifdef COUNTDOWN15_WRAPCNT_EN
      r_wraps <= '0;
`endif
    end else begin
      r_tc <= 1'b0;
      if (r_state == S_RUN && en) begin
        if (r_out != '0) begin
          r_out <= r_out - ONE;
          // tc marks only a decrement into 0, never a load of 0 or a wrap.
          if (r_out == ONE) begin
            r_tc <= 1'b1;
            if (!r_mode) r_state <= S_DONE;
          end
        end else if (r_mode) begin
          r_out <= MAXV;
`ifdef COUNTDOWN15_WRAPCNT_EN
          if (r_wraps != 4'hF) r_wraps <= r_wraps + 4'd1;
`endif
        end else begin
          r_state <= S_DONE;
        end
      end
    end
  end

  assign out  = r_out;
  assign tc   = r_tc;
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
`ifdef COUNTDOWN15_WRAPCNT_EN
  assign wraps = r_wraps;
`endif

endmodule

// File: tb/tb_countdown15.sv
// Self-checking bench for countdown15: vector table plus reset and wrap sequences.
module tb_countdown15;

  logic       clk;
  logic       reset;
  logic [3:0] init;
  logic       set;
  logic       en;
  logic       mode;
  logic [3:0] out;
  logic       tc;
  logic       busy;
  logic       done;
`ifdef COUNTDOWN15_WRAPCNT_EN
  logic [3:0] wraps;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  countdown15 #(.MOD(15), .WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .set   (set),
    .en    (en),
    .mode  (mode),
    .out   (out),
    .tc    (tc),
    .busy  (busy),
`ifdef COUNTDOWN15_WRAPCNT_EN
    .done  (done),
    .wraps (wraps)
`else
    .done  (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       set;
    logic [3:0] init;
    logic       mode;
    logic       en;
    logic [3:0] e_out;
    logic       e_tc;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_wraps;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic s, input logic [3:0] i, input logic m,
                              input logic e, input logic [3:0] o, input logic t,
                              input logic b, input logic d, input logic [3:0] w);
    vec_t v;
    v.set = s; v.init = i; v.mode = m; v.en = e;
    v.e_out = o; v.e_tc = t; v.e_busy = b; v.e_done = d; v.e_wraps = w;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic apply(input logic s, input logic [3:0] i, input logic m, input logic e);
    set = s; init = i; mode = m; en = e;
    @(posedge clk);
    #1;
  endtask

  int tc_count;
  int tc_back2back;
  logic prev_tc;

  initial begin
    //              set init mode en  out  tc busy done wraps
    vecs[0]  = mk(0, 4'd0,  0, 1, 4'd0,  0, 0, 0, 4'd0); // IDLE ignores en
    vecs[1]  = mk(1, 4'd5,  0, 0, 4'd5,  0, 1, 0, 4'd0);
    vecs[2]  = mk(0, 4'd0,  0, 1, 4'd4,  0, 1, 0, 4'd0);
    vecs[3]  = mk(0, 4'd0,  0, 1, 4'd3,  0, 1, 0, 4'd0);
    vecs[4]  = mk(0, 4'd0,  0, 1, 4'd2,  0, 1, 0, 4'd0);
    vecs[5]  = mk(0, 4'd0,  0, 1, 4'd1,  0, 1, 0, 4'd0);
    vecs[6]  = mk(0, 4'd0,  0, 1, 4'd0,  1, 0, 1, 4'd0);
    vecs[7]  = mk(0, 4'd0,  0, 1, 4'd0,  0, 0, 1, 4'd0);
    vecs[8]  = mk(0, 4'd0,  1, 1, 4'd0,  0, 0, 1, 4'd0); // mode change without set
    vecs[9]  = mk(1, 4'd2,  1, 0, 4'd2,  0, 1, 0, 4'd0);
    vecs[10] = mk(0, 4'd0,  0, 1, 4'd1,  0, 1, 0, 4'd0);
    vecs[11] = mk(0, 4'd0,  0, 1, 4'd0,  1, 1, 0, 4'd0);
    vecs[12] = mk(0, 4'd0,  0, 1, 4'd14, 0, 1, 0, 4'd1);
    vecs[13] = mk(0, 4'd0,  0, 1, 4'd13, 0, 1, 0, 4'd1);
    vecs[14] = mk(0, 4'd0,  0, 0, 4'd13, 0, 1, 0, 4'd1);
    vecs[15] = mk(0, 4'd0,  0, 0, 4'd13, 0, 1, 0, 4'd1);
    vecs[16] = mk(0, 4'd0,  0, 0, 4'd13, 0, 1, 0, 4'd1);
    vecs[17] = mk(1, 4'd15, 0, 0, 4'd14, 0, 1, 0, 4'd0); // saturating load
    vecs[18] = mk(1, 4'd0,  1, 0, 4'd0,  0, 1, 0, 4'd0);
    vecs[19] = mk(0, 4'd0,  0, 0, 4'd0,  0, 1, 0, 4'd0);
    vecs[20] = mk(0, 4'd0,  0, 1, 4'd14, 0, 1, 0, 4'd1);
    vecs[21] = mk(1, 4'd1,  0, 0, 4'd1,  0, 1, 0, 4'd0);
    vecs[22] = mk(1, 4'd9,  0, 1, 4'd9,  0, 1, 0, 4'd0); // set beats en at out=1
    vecs[23] = mk(0, 4'd0,  0, 1, 4'd8,  0, 1, 0, 4'd0);
    vecs[24] = mk(1, 4'd0,  0, 0, 4'd0,  0, 1, 0, 4'd0);
    vecs[25] = mk(0, 4'd0,  0, 1, 4'd0,  0, 0, 1, 4'd0);
    vecs[26] = mk(0, 4'd0,  0, 1, 4'd0,  0, 0, 1, 4'd0);

    reset = 1'b1; set = 1'b0; init = '0; mode = 1'b0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {28'd0, out, tc, busy, done}, 32'd0);
`ifdef COUNTDOWN15_WRAPCNT_EN
    check("reset_wraps", {28'd0, wraps}, 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].set, vecs[i].init, vecs[i].mode, vecs[i].en);
      check($sformatf("vec[%0d] out,tc,busy,done", i),
            {25'd0, out, tc, busy, done},
            {25'd0, vecs[i].e_out, vecs[i].e_tc, vecs[i].e_busy, vecs[i].e_done});
`ifdef COUNTDOWN15_WRAPCNT_EN
      check($sformatf("vec[%0d] wraps", i), {28'd0, wraps}, {28'd0, vecs[i].e_wraps});
`endif
    end

    // Asynchronous reset mid-count at out=7, checked between clock edges.
    apply(1'b1, 4'd9, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b1);
    apply(1'b0, 4'd0, 1'b0, 1'b1);
    check("pre_reset_out", {28'd0, out}, 32'd7);
    reset = 1'b1;
    #2;
    check("async_reset", {28'd0, out, tc, busy, done}, 32'd0);
`ifdef COUNTDOWN15_WRAPCNT_EN
    check("async_reset_wraps", {28'd0, wraps}, 32'd0);
`endif
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 4'd0, 1'b1, 1'b1);
      check($sformatf("idle_after_reset[%0d]", k), {28'd0, out, tc, busy, done}, 32'd0);
    end
    apply(1'b1, 4'd3, 1'b0, 1'b0);
    check("load_after_reset", {28'd0, out, tc, busy, done}, {28'd0, 4'd3, 1'b0, 1'b1, 1'b0});

    // 286 enabled edges from a continuous load of 0 produce 20 wraps and 19 tc pulses.
    apply(1'b1, 4'd0, 1'b1, 1'b0);
    tc_count = 0; tc_back2back = 0; prev_tc = 1'b0;
    for (int k = 0; k < 286; k++) begin
      apply(1'b0, 4'd0, 1'b0, 1'b1);
      if (tc) tc_count++;
      if (tc && prev_tc) tc_back2back++;
      prev_tc = tc;
    end
    check("cont_tc_count", tc_count, 32'd19);
    check("cont_tc_width", tc_back2back, 32'd0);
    check("cont_final_out", {28'd0, out, tc, busy, done}, {28'd0, 4'd14, 1'b0, 1'b1, 1'b0});
`ifdef COUNTDOWN15_WRAPCNT_EN
    check("wraps_saturated", {28'd0, wraps}, 32'd15);
    apply(1'b1, 4'd4, 1'b1, 1'b1);
    check("wraps_cleared_by_set", {28'd0, wraps, out}, {24'd0, 4'd0, 4'd4});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
